branch_resolve: RTL and testbench
=================================

# branch_resolve

Resolves conditional and unconditional branches from the execute stage of the 16-bit pipeline, and owns the architectural Z/V/N flag register. It registers the branch target that execute computes, checks the condition code against the flags, and drives the fetch redirect. It also sequences the two-cycle flush of wrong-path instructions in IF and ID. It sits between EX and the PC/fetch logic and consumes execute's `dst`, `zr`, `addResult`, `sawBranch` and `branchOp`.

## Interface
Parameters:
- `WIDTH`, 16: datapath/PC width.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: pipeline hold; freezes all state when 1.
- `ex_valid` in 1: EX holds a real instruction this cycle.
- `flag_we` in 1: EX instruction writes flags (arithmetic ops).
- `zr` in 1: zero result from EX ALU.
- `ov` in 1: overflow from EX ALU.
- `neg` in 1: `dst[15]` of EX result.
- `sawBranch` in 1: EX instruction is a branch.
- `branchOp` in 3: condition code.
- `addResult` in WIDTH: branch target from EX.
- `redirect` out 1: load `redirect_pc` into PC.
- `redirect_pc` out WIDTH: registered target.
- `flush_if` out 1: squash the IF/ID register.
- `flush_id` out 1: squash the ID/EX register.
- `flags` out 3: {Z,V,N} architectural flags.
- `br_count` out 16: branches resolved (see Configuration).
- `taken_count` out 16: branches taken (see Configuration).

## Operation
- Accept: `acc = ex_valid & ~stall & (state==IDLE)`. EX inputs are ignored outside IDLE because they belong to wrong-path instructions.
- Flag register: loads {zr,ov,neg} when `acc & flag_we`. Reset value 3'b000.
- Condition uses the flags value before this cycle's update. If `flag_we` and `sawBranch` are both set, the branch sees the old flags and the flags then update.
- branchOp encoding:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GTE: Z=1 | N=0
  - 101 LTE: Z=1 | N=1
  - 110 OVFL: V=1
  - 111 UNCOND: always taken
- `take = acc & sawBranch & cond`. On `take`, `redirect_pc <= addResult` with no arithmetic here; the target is already full WIDTH and wraps naturally.
- FSM, 3 states:
  - IDLE: all control outputs 0. `take` → REDIRECT; otherwise stay.
  - REDIRECT: `redirect=1`, `flush_if=1`, `flush_id=1`. Next state → SHADOW.
  - SHADOW: `flush_id=1`, which kills the instruction fetched during the REDIRECT cycle. Next state → IDLE.
- Not-taken branches cause no state change and no outputs.
- `stall=1` in any state: state, flags, `redirect_pc` and counters hold, and outputs keep their current values, so `redirect` stays high across a stall in REDIRECT.
- `rst` overrides everything, including mid-REDIRECT/SHADOW. It takes effect at the next edge: state IDLE, outputs 0, flags 0, `redirect_pc` 0, counters 0.

## Timing
- Branch accepted at edge N → `redirect`/`flush_if`/`flush_id` high during cycle N+1; `flush_id` high during N+2; IDLE in N+3. A stall extends each state one cycle per stall cycle.
- Minimum spacing between two taken branches: 3 cycles.
- Flag latency: flags written at edge N are visible to a branch accepted at edge N+1.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Configuration
- `BRANCH_STATS_EN`:
  - Defined: `br_count` increments on every `acc & sawBranch`. `taken_count` increments on `take`. Both are 16-bit and saturate at 16'hFFFF, hold under stall, and clear on reset.
  - Undefined: both ports are tied to 0 and no counter logic is built.

## Test plan
- Reset mid-flush: take a branch, assert `rst` in the REDIRECT cycle → next cycle IDLE, all outputs 0, flags 0.
- EQ branch: first an ALU op with `flag_we=1`, zr=1. Next cycle a branch with `branchOp=001`, `addResult=16'h0040` → `redirect=1` and `redirect_pc=16'h0040` one cycle later, then `flush_id` one further cycle, then IDLE.
- Not taken plus simultaneous flag write: flags Z=0, N=1; branch GT (010) with `flag_we=1`, zr=1 → no redirect, and flags become {1,ov,neg}.
- Wrong-path ignore: during REDIRECT/SHADOW, drive `ex_valid=1`, `sawBranch=1`, UNCOND, `flag_we=1` → flags unchanged, no second redirect.
- Stall hold: take UNCOND to 16'hFFFF, hold `stall=1` for 3 cycles in REDIRECT → `redirect` stays 1 for 4 cycles total, then SHADOW for 1, then IDLE.
- With `BRANCH_STATS_EN`: issue 5 branches, 2 taken → `br_count=5`, `taken_count=2`. Force `br_count` to 16'hFFFF and issue another branch → `br_count` stays 16'hFFFF.

Source files
------------

// File: rtl/branch_resolve.sv
// Branch resolution, architectural {Z,V,N} flag register and IF/ID flush sequencing.
// Optional per-branch statistics counters are built when BRANCH_STATS_EN is defined.
module branch_resolve #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             flag_we,
  input  logic             zr,
  input  logic             ov,
  input  logic             neg,
  input  logic             sawBranch,
  input  logic [2:0]       branchOp,
  input  logic [WIDTH-1:0] addResult,
  output logic             redirect,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic [2:0]       flags,
  output logic [15:0]      br_count,
  output logic [15:0]      taken_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    SHADOW   = 2'd2
  } state_t;

  state_t state;
  logic   acc;
  logic   cond;
  logic   take;
  logic   flag_z;
  logic   flag_v;
  logic   flag_n;

  assign flag_z = flags[2];
  assign flag_v = flags[1];
  assign flag_n = flags[0];

  // Outside IDLE the EX stage holds wrong-path instructions, so they are ignored.
  assign acc  = ex_valid & ~stall & (state == IDLE);
  assign take = acc & sawBranch & cond;

  always_comb begin
    cond = 1'b0;
    case (branchOp)
      3'b000:  cond = ~flag_z;
      3'b001:  cond = flag_z;
      3'b010:  cond = ~flag_z & ~flag_n;
      3'b011:  cond = flag_n;
      3'b100:  cond = flag_z | ~flag_n;
      3'b101:  cond = flag_z | flag_n;
      3'b110:  cond = flag_v;
      default: cond = 1'b1;
    endcase
  end

  // The condition above reads the flags before this edge, so a branch that also
  // writes flags sees the old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      redirect    <= 1'b0;
      flush_if    <= 1'b0;
      flush_id    <= 1'b0;
      redirect_pc <= '0;
      flags       <= 3'b000;
    end else if (!stall) begin
      if (acc && flag_we) begin
        flags <= {zr, ov, neg};
      end
      case (state)
        IDLE: begin
          if (take) begin
            state       <= REDIRECT;
            redirect    <= 1'b1;
            flush_if    <= 1'b1;
            flush_id    <= 1'b1;
            redirect_pc <= addResult;
          end
        end
        REDIRECT: begin
          state    <= SHADOW;
          redirect <= 1'b0;
          flush_if <= 1'b0;
          flush_id <= 1'b1;
        end
        SHADOW: begin
          state    <= IDLE;
          redirect <= 1'b0;
          flush_if <= 1'b0;
          flush_id <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          redirect <= 1'b0;
          flush_if <= 1'b0;
          flush_id <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] br_count_q;
  logic [15:0] taken_count_q;

  // Saturating counters; they share the stall/reset behaviour of the rest of the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q    <= 16'h0000;
      taken_count_q <= 16'h0000;
    end else begin
      if (acc && sawBranch && (br_count_q != 16'hFFFF)) begin
        br_count_q <= br_count_q + 16'h0001;
      end
      if (take && (taken_count_q != 16'hFFFF)) begin
        taken_count_q <= taken_count_q + 16'h0001;
      end
    end
  end

  assign br_count    = br_count_q;
  assign taken_count = taken_count_q;
`else
  assign br_count    = 16'h0000;
  assign taken_count = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: expected redirects are queued by the stimulus
// and checked by an independent monitor watching the redirect/flush outputs.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        ex_valid = 1'b0;
  logic        flag_we = 1'b0;
  logic        zr = 1'b0;
  logic        ov = 1'b0;
  logic        neg = 1'b0;
  logic        sawBranch = 1'b0;
  logic [2:0]  branchOp = 3'b000;
  logic [15:0] addResult = 16'h0000;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        flush_if;
  logic        flush_id;
  logic [2:0]  flags;
  logic [15:0] br_count;
  logic [15:0] taken_count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] pc;
    int          len;
    bit          shadow;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  branch_resolve #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .flag_we(flag_we),
    .zr(zr), .ov(ov), .neg(neg), .sawBranch(sawBranch), .branchOp(branchOp),
    .addResult(addResult), .redirect(redirect), .redirect_pc(redirect_pc),
    .flush_if(flush_if), .flush_id(flush_id), .flags(flags),
    .br_count(br_count), .taken_count(taken_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic ev, input logic sb, input logic [2:0] op,
                               input logic [15:0] addr, input logic fwe, input logic z,
                               input logic o, input logic n, input logic st);
    ex_valid  = ev;
    sawBranch = sb;
    branchOp  = op;
    addResult = addr;
    flag_we   = fwe;
    zr        = z;
    ov        = o;
    neg       = n;
    stall     = st;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 3'b000, 16'h0000, 0, 0, 0, 0, 0);
  endtask

  task automatic pushExp(input logic [15:0] pc, input int len, input bit shadow);
    exp_t e;
    e.pc = pc;
    e.len = len;
    e.shadow = shadow;
    exp_q.push_back(e);
  endtask

  // Monitor: each rising redirect consumes one expected entry and checks the flush tail.
  initial begin
    forever begin
      @(negedge clk);
      if (redirect === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_redirect: got redirect_pc %0h, expected no redirect", redirect_pc);
          for (int k = 0; k < 32 && redirect === 1'b1; k++) @(negedge clk);
        end else begin
          exp_t e;
          int len;
          e = exp_q.pop_front();
          checkOutput("redirect_pc", {16'h0, redirect_pc}, {16'h0, e.pc});
          checkOutput("flush_if_in_redirect", {31'h0, flush_if}, 32'h1);
          checkOutput("flush_id_in_redirect", {31'h0, flush_id}, 32'h1);
          len = 1;
          for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (redirect !== 1'b1) break;
            len++;
          end
          checkOutput("redirect_length", len, e.len);
          checkOutput("flush_id_after_redirect", {31'h0, flush_id}, {31'h0, e.shadow});
          checkOutput("flush_if_after_redirect", {31'h0, flush_if}, 32'h0);
          if (e.shadow) begin
            @(negedge clk);
            checkOutput("flush_id_after_shadow", {31'h0, flush_id}, 32'h0);
            checkOutput("redirect_after_shadow", {31'h0, redirect}, 32'h0);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Condition table: flags {Z,V,N} preset, branch code, hand-computed taken.
  logic [2:0] tflags [12] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b000, 3'b001,
                              3'b101, 3'b000, 3'b001, 3'b010, 3'b000, 3'b000};
  logic [2:0] tops   [12] = '{3'd0, 3'd0, 3'd2, 3'd3, 3'd3, 3'd4,
                              3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd7};
  bit         ttaken [12] = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 0, 1};

  initial begin
    idle(2);
    rst = 1'b0;
    checkOutput("reset_redirect", {31'h0, redirect}, 32'h0);
    checkOutput("reset_flush", {30'h0, flush_if, flush_id}, 32'h0);
    checkOutput("reset_flags", {29'h0, flags}, 32'h0);
    checkOutput("reset_pc", {16'h0, redirect_pc}, 32'h0);

    // EQ branch after a zero-result ALU op
    applyStimulus(1, 0, 3'b000, 16'h0000, 1, 1, 0, 0, 0);
    checkOutput("eq_flags", {29'h0, flags}, 32'h4);
    pushExp(16'h0040, 1, 1);
    applyStimulus(1, 1, 3'b001, 16'h0040, 0, 0, 0, 0, 0);
    checkOutput("eq_redirect", {31'h0, redirect}, 32'h1);
    idle(2);
    checkOutput("eq_idle", {30'h0, flush_if, flush_id}, 32'h0);

    // Not-taken GT while the same instruction writes new flags
    applyStimulus(1, 0, 3'b000, 16'h0000, 1, 0, 0, 1, 0);
    applyStimulus(1, 1, 3'b010, 16'h0200, 1, 1, 1, 0, 0);
    checkOutput("gt_not_taken", {31'h0, redirect}, 32'h0);
    checkOutput("gt_flags_update", {29'h0, flags}, 32'h6);
    idle(1);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 0, 3'b000, 16'h0000, 1, tflags[i][2], tflags[i][1], tflags[i][0], 0);
      checkOutput("cond_flags", {29'h0, flags}, {29'h0, tflags[i]});
      if (ttaken[i]) pushExp(16'h0100 + 16'(i), 1, 1);
      applyStimulus(1, 1, tops[i], 16'h0100 + 16'(i), 0, 0, 0, 0, 0);
      checkOutput("cond_taken", {31'h0, redirect}, {31'h0, ttaken[i]});
      idle(2);
    end

    // Wrong-path instructions during REDIRECT and SHADOW are ignored
    applyStimulus(1, 0, 3'b000, 16'h0000, 1, 0, 0, 0, 0);
    pushExp(16'h1234, 1, 1);
    applyStimulus(1, 1, 3'b111, 16'h1234, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 3'b111, 16'hBEEF, 1, 1, 1, 1, 0);
    applyStimulus(1, 1, 3'b111, 16'hBEEF, 1, 1, 1, 1, 0);
    checkOutput("wrong_path_flags", {29'h0, flags}, 32'h0);
    checkOutput("wrong_path_pc", {16'h0, redirect_pc}, 32'h1234);
    idle(2);

    // Stall in IDLE blocks acceptance
    applyStimulus(1, 1, 3'b111, 16'h0777, 1, 1, 0, 0, 1);
    checkOutput("stall_idle_redirect", {31'h0, redirect}, 32'h0);
    checkOutput("stall_idle_flags", {29'h0, flags}, 32'h0);

    // Stall holds REDIRECT for three extra cycles
    pushExp(16'hFFFF, 4, 1);
    applyStimulus(1, 1, 3'b111, 16'hFFFF, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 3'b111, 16'h0001, 1, 1, 1, 1, 1);
    checkOutput("stall_hold_redirect", {31'h0, redirect}, 32'h1);
    checkOutput("stall_hold_pc", {16'h0, redirect_pc}, 32'hFFFF);
    idle(3);

    // Reset during REDIRECT aborts the flush
    pushExp(16'h0ABC, 1, 0);
    applyStimulus(1, 1, 3'b111, 16'h0ABC, 1, 1, 0, 0, 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checkOutput("rst_mid_redirect", {31'h0, redirect}, 32'h0);
    checkOutput("rst_mid_flush", {30'h0, flush_if, flush_id}, 32'h0);
    checkOutput("rst_mid_flags", {29'h0, flags}, 32'h0);
    checkOutput("rst_mid_pc", {16'h0, redirect_pc}, 32'h0);
    idle(2);

    // Five branches, two taken (flags are zero so OVFL is not taken)
    for (int i = 0; i < 5; i++) begin
      if (i == 1 || i == 3) begin
        pushExp(16'h3000 + 16'(i), 1, 1);
        applyStimulus(1, 1, 3'b111, 16'h3000 + 16'(i), 0, 0, 0, 0, 0);
      end else begin
        applyStimulus(1, 1, 3'b110, 16'h3000 + 16'(i), 0, 0, 0, 0, 0);
      end
      idle(2);
    end
`ifdef BRANCH_STATS_EN
    checkOutput("br_count", {16'h0, br_count}, 32'd5);
    checkOutput("taken_count", {16'h0, taken_count}, 32'd2);
    force dut.br_count_q = 16'hFFFF;
    #1;
    release dut.br_count_q;
    applyStimulus(1, 1, 3'b110, 16'h4000, 0, 0, 0, 0, 0);
    checkOutput("br_count_saturate", {16'h0, br_count}, 32'hFFFF);
    checkOutput("taken_count_hold", {16'h0, taken_count}, 32'd2);
`else
    checkOutput("br_count_tied", {16'h0, br_count}, 32'd0);
    checkOutput("taken_count_tied", {16'h0, taken_count}, 32'd0);
`endif
    idle(4);
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
